// File: rtl/atomrvcore_lsu_pkg.sv
// Shared constants and types for the load/store unit.
package atomrvcore_lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the byte offset inside a 32-bit word
    localparam int OFFSET_W = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_MERGE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/atomrvcore_lsu_align.sv
// Lane alignment: extracts/extends load data and merges sub-word store data
// into a full DCCM word. Purely combinational.
module atomrvcore_lsu_align
    import atomrvcore_lsu_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic [2:0]           funct3_i,
    input  logic [OFFSET_W-1:0]  offset_i,
    input  logic [DATAWIDTH-1:0] word_i,
    input  logic [DATAWIDTH-1:0] store_data_i,
    output logic [DATAWIDTH-1:0] load_data_o,
    output logic [DATAWIDTH-1:0] merged_o
);

    logic [DATAWIDTH-1:0] w_lane;
    logic [DATAWIDTH-1:0] w_mask;
    logic [DATAWIDTH-1:0] w_ins;
    logic [4:0]           w_shamt;

    assign w_shamt = {offset_i, 3'b000};
    assign w_lane  = word_i >> w_shamt;

    // Load extract and sign/zero extension of the addressed lane
    always_comb begin
        load_data_o = word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{(DATAWIDTH-8){w_lane[7]}}, w_lane[7:0]};
            F3_H:    load_data_o = {{(DATAWIDTH-16){w_lane[15]}}, w_lane[15:0]};
            F3_BU:   load_data_o = {{(DATAWIDTH-8){1'b0}}, w_lane[7:0]};
            F3_HU:   load_data_o = {{(DATAWIDTH-16){1'b0}}, w_lane[15:0]};
            default: load_data_o = word_i;
        endcase
    end

    // Store merge: replace the byte/halfword lane at the offset, keep the rest
    always_comb begin
        w_mask = '0;
        w_ins  = '0;
        if (funct3_i[1:0] == 2'b00) begin
            w_mask = {{(DATAWIDTH-8){1'b0}}, 8'hFF} << w_shamt;
            w_ins  = {{(DATAWIDTH-8){1'b0}}, store_data_i[7:0]} << w_shamt;
        end else begin
            w_mask = {{(DATAWIDTH-16){1'b0}}, 16'hFFFF} << w_shamt;
            w_ins  = {{(DATAWIDTH-16){1'b0}}, store_data_i[15:0]} << w_shamt;
        end
        merged_o = (word_i & ~w_mask) | (w_ins & w_mask);
    end

endmodule

// File: rtl/atomrvcore_lsu.sv
// Memory-stage load/store unit driving a word-only DCCM port. Sub-word stores
// become read-modify-write; loads take one wait cycle for DCCM read data.
// Handshake: a request transfers on a cycle where req_valid_i && ready_o; while
// ready_o is low the upstream stage holds its request and it is ignored here.
module atomrvcore_lsu
    import atomrvcore_lsu_pkg::*;
#(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    input  logic                        mem_rd_i,
    input  logic                        mem_wr_i,
    input  logic [2:0]                  funct3_i,
    input  logic [DATAWIDTH-1:0]        addr_i,
    input  logic [DATAWIDTH-1:0]        store_data_i,
    input  logic [REG_ADRESS_WIDTH-1:0] rd_i,
    input  logic                        rwr_en_i,
    input  logic [DATAWIDTH-1:0]        result_i,
    output logic                        ready_o,
    output logic [DATAWIDTH-1:0]        dccm_addr_o,
    output logic                        dccm_rd_en_o,
    output logic                        dccm_wr_en_o,
    output logic [DATAWIDTH-1:0]        dccm_wdata_o,
    input  logic [DATAWIDTH-1:0]        dccm_rdata_i,
    output logic                        wb_en_o,
    output logic [REG_ADRESS_WIDTH-1:0] wb_rd_o,
    output logic [DATAWIDTH-1:0]        wb_data_o,
    output logic                        err_o
);

    lsu_state_e r_state;
    lsu_state_e w_next_state;

    logic [REG_ADRESS_WIDTH-1:0] r_rd;
    logic [2:0]                  r_funct3;
    logic [OFFSET_W-1:0]         r_off;
    logic [DATAWIDTH-1:0]        r_addr_word;
    logic [DATAWIDTH-1:0]        r_store_data;
    logic                        r_wb_en;
    logic [REG_ADRESS_WIDTH-1:0] r_wb_rd;
    logic [DATAWIDTH-1:0]        r_wb_data;
    logic                        r_err;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_is_mem;
    logic                 w_illegal;
    logic                 w_misaligned;
    logic                 w_bad;
    logic [DATAWIDTH-1:0] w_addr_word;
    logic [DATAWIDTH-1:0] w_load_data;
    logic [DATAWIDTH-1:0] w_merged;

    assign w_ready     = (r_state == IDLE) && !rst_i;
    assign w_accept    = req_valid_i && w_ready;
    assign w_is_mem    = mem_rd_i || mem_wr_i;
    assign w_addr_word = {addr_i[DATAWIDTH-1:2], 2'b00};

    // Illegal: both directions, reserved funct3, or unsigned-size store
    assign w_illegal = (mem_rd_i && mem_wr_i)
                    || (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111)
                    || (mem_wr_i && funct3_i[2]);
    assign w_misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0])
                       || ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    assign w_bad = w_is_mem && (w_illegal || w_misaligned);

    assign ready_o   = w_ready;
    assign wb_en_o   = r_wb_en;
    assign wb_rd_o   = r_wb_rd;
    assign wb_data_o = r_wb_data;
    assign err_o     = r_err;

    // Only the wait states consume the aligner, so it always sees registered request copies
    atomrvcore_lsu_align #(.DATAWIDTH(DATAWIDTH)) u_align (
        .funct3_i     (r_funct3),
        .offset_i     (r_off),
        .word_i       (dccm_rdata_i),
        .store_data_i (r_store_data),
        .load_data_o  (w_load_data),
        .merged_o     (w_merged)
    );

    // Next-state and DCCM port drive; reset forces the port quiet
    always_comb begin
        w_next_state = r_state;
        dccm_addr_o  = '0;
        dccm_rd_en_o = 1'b0;
        dccm_wr_en_o = 1'b0;
        dccm_wdata_o = '0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_mem && !w_bad) begin
                    dccm_addr_o = w_addr_word;
                    if (mem_rd_i) begin
                        dccm_rd_en_o = 1'b1;
                        w_next_state = LOAD_WAIT;
                    end else if (funct3_i == F3_W) begin
                        dccm_wr_en_o = 1'b1;
                        dccm_wdata_o = store_data_i;
                    end else begin
                        dccm_rd_en_o = 1'b1;
                        w_next_state = RMW_MERGE;
                    end
                end
            end
            LOAD_WAIT: begin
                dccm_addr_o  = r_addr_word;
                w_next_state = IDLE;
            end
            RMW_MERGE: begin
                dccm_addr_o  = r_addr_word;
                dccm_wr_en_o = 1'b1;
                dccm_wdata_o = w_merged;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (rst_i) begin
            dccm_addr_o  = '0;
            dccm_rd_en_o = 1'b0;
            dccm_wr_en_o = 1'b0;
            dccm_wdata_o = '0;
        end
    end

    // State register, request capture and writeback/error pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_rd         <= '0;
            r_funct3     <= '0;
            r_off        <= '0;
            r_addr_word  <= '0;
            r_store_data <= '0;
            r_wb_en      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_wb_en <= 1'b0;
            r_err   <= 1'b0;
            if (w_accept) begin
                r_rd         <= rd_i;
                r_funct3     <= funct3_i;
                r_off        <= addr_i[OFFSET_W-1:0];
                r_addr_word  <= w_addr_word;
                r_store_data <= store_data_i;
                if (w_bad) begin
                    r_err <= 1'b1;
                end else if (!w_is_mem) begin
                    r_wb_en   <= rwr_en_i;
                    r_wb_rd   <= rd_i;
                    r_wb_data <= result_i;
                end
            end
            if (r_state == LOAD_WAIT) begin
                r_wb_en   <= 1'b1;
                r_wb_rd   <= r_rd;
                r_wb_data <= w_load_data;
            end
        end
    end

endmodule
